// File: rtl/sprite_frame_scheduler.sv
// Sprite position scheduler and pixel arbiter for the VGA overlay.
// Game logic writes positions into shadow registers during LOAD. The
// shadow copies are moved to live registers one slot per cycle in
// COMMIT, which runs in the vertical back porch. Live positions are
// matched against internally generated pixel counters in a two-stage
// pipeline: stage 1 holds per-slot hits, stage 2 holds the priority
// winner and the colour override.
module sprite_frame_scheduler #(
  parameter int NUM_SPRITES = 4,
  parameter int SPRITE_W    = 32,
  parameter int SPRITE_H    = 32,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic                        iVGA_CLK,
  input  logic                        reset,
  input  logic                        blank_n,
  input  logic                        vs,
  input  logic                        pos_wr_valid,
  output logic                        pos_wr_ready,
  input  logic [1:0]                  pos_wr_id,
  input  logic [9:0]                  pos_wr_x,
  input  logic [8:0]                  pos_wr_y,
  input  logic [NUM_SPRITES-1:0]      sprite_en,
  input  logic [24*NUM_SPRITES-1:0]   sprite_colors,
  input  logic [23:0]                 bg_color,
  output logic [23:0]                 pix_color,
  output logic                        pix_hit,
  output logic [1:0]                  pix_id,
  output logic                        frame_tick,
  output logic [1:0]                  state
);

  typedef enum logic [1:0] {SCAN = 2'd0, LOAD = 2'd1, COMMIT = 2'd2} state_t;

  localparam int CW = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

  state_t                 state_reg, state_next;
  logic [CW-1:0]          commit_cnt_reg;
  logic                   vs_d_reg;
  logic                   vs_fall, vs_rise;
  logic                   frame_tick_reg;
  logic                   wr_fire;
  logic [9:0]             x_cnt_reg;
  logic [8:0]             y_cnt_reg;
  logic [NUM_SPRITES-1:0] hit_next, hit_reg;
  logic [1:0]             win_id;
  logic [23:0]            slot_color [NUM_SPRITES];
  logic                   pix_hit_reg;
  logic [1:0]             pix_id_reg;
  logic [23:0]            pix_color_reg;

  assign vs_fall = vs_d_reg & ~vs;
  assign vs_rise = ~vs_d_reg & vs;
  assign wr_fire = (state_reg == LOAD) && pos_wr_valid;

  // Sync edge history, frame pulse, FSM state and commit slot counter.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      vs_d_reg       <= 1'b0;
      frame_tick_reg <= 1'b0;
      state_reg      <= SCAN;
      commit_cnt_reg <= '0;
    end else begin
      vs_d_reg       <= vs;
      frame_tick_reg <= (state_reg == SCAN) && vs_fall;
      state_reg      <= state_next;
      if (state_reg == COMMIT) commit_cnt_reg <= commit_cnt_reg + 1'b1;
      else                     commit_cnt_reg <= '0;
    end
  end

  // Next-state logic; the write port is open only while loading.
  always_comb begin
    state_next   = state_reg;
    pos_wr_ready = 1'b0;
    case (state_reg)
      SCAN: begin
        if (vs_fall) state_next = LOAD;
      end
      LOAD: begin
        pos_wr_ready = 1'b1;
        if (vs_rise) state_next = COMMIT;
      end
      COMMIT: begin
        if (commit_cnt_reg == CW'(NUM_SPRITES - 1)) state_next = SCAN;
      end
      default: state_next = SCAN;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SPRITES; gi++) begin : g_slot
      logic [9:0] shadow_x_reg, live_x_reg;
      logic [8:0] shadow_y_reg, live_y_reg;

      // Shadow capture during LOAD, shadow-to-live copy in this slot's commit cycle.
      always_ff @(posedge iVGA_CLK) begin
        if (reset) begin
          shadow_x_reg <= '0;
          shadow_y_reg <= '0;
          live_x_reg   <= '0;
          live_y_reg   <= '0;
        end else begin
          if (wr_fire && (pos_wr_id == 2'(gi))) begin
            shadow_x_reg <= pos_wr_x;
            shadow_y_reg <= pos_wr_y;
          end
          if ((state_reg == COMMIT) && (commit_cnt_reg == CW'(gi))) begin
            live_x_reg <= shadow_x_reg;
            live_y_reg <= shadow_y_reg;
          end
        end
      end

      // Right/bottom bounds are widened by one bit so sprites near the
      // counter limits clip instead of wrapping to the left/top edge.
      assign hit_next[gi] = sprite_en[gi] && blank_n
          && ({1'b0, x_cnt_reg} >= {1'b0, live_x_reg})
          && ({1'b0, x_cnt_reg} <  ({1'b0, live_x_reg} + 11'(SPRITE_W)))
          && ({1'b0, y_cnt_reg} >= {1'b0, live_y_reg})
          && ({1'b0, y_cnt_reg} <  ({1'b0, live_y_reg} + 10'(SPRITE_H)));

      assign slot_color[gi] = sprite_colors[24*gi +: 24];
    end
  endgenerate

  // Pixel counters: cleared in vertical sync, advanced on visible pixels.
  always_ff @(posedge iVGA_CLK) begin
    if (reset || !vs) begin
      x_cnt_reg <= '0;
      y_cnt_reg <= '0;
    end else if (blank_n) begin
      if (x_cnt_reg == 10'(H_ACTIVE - 1)) begin
        x_cnt_reg <= '0;
        if (y_cnt_reg != 9'(V_ACTIVE - 1)) y_cnt_reg <= y_cnt_reg + 1'b1;
      end else begin
        x_cnt_reg <= x_cnt_reg + 1'b1;
      end
    end
  end

  // Stage 1: per-slot hit flags for the pixel under the counters.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) hit_reg <= '0;
    else       hit_reg <= hit_next;
  end

  // Priority encoder: the lowest-numbered hitting slot wins.
  always_comb begin
    win_id = 2'd0;
    for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
      if (hit_reg[i]) win_id = 2'(i);
    end
  end

  // Stage 2: winner, hit flag and colour override.
  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      pix_hit_reg   <= 1'b0;
      pix_id_reg    <= 2'd0;
      pix_color_reg <= 24'd0;
    end else begin
      pix_hit_reg   <= |hit_reg;
      pix_id_reg    <= win_id;
      pix_color_reg <= (|hit_reg) ? slot_color[win_id] : bg_color;
    end
  end

  assign pix_hit    = pix_hit_reg;
  assign pix_id     = pix_id_reg;
  assign pix_color  = pix_color_reg;
  assign frame_tick = frame_tick_reg;
  assign state      = state_reg;

endmodule

// File: tb/tb_sprite_frame_scheduler.sv
// Directed bench for sprite_frame_scheduler: hand-sequenced frame
// protocol checks plus a table of pixel vectors checked two cycles
// after each pixel is presented.
module tb_sprite_frame_scheduler;

  localparam logic [23:0] C0 = 24'h111111;
  localparam logic [23:0] C1 = 24'h222222;
  localparam logic [23:0] C2 = 24'h333333;
  localparam logic [23:0] C3 = 24'h444444;
  localparam logic [23:0] BG = 24'h0000AA;

  logic        iVGA_CLK = 1'b0;
  logic        reset, blank_n, vs, pos_wr_valid, pos_wr_ready;
  logic [1:0]  pos_wr_id;
  logic [9:0]  pos_wr_x;
  logic [8:0]  pos_wr_y;
  logic [3:0]  sprite_en;
  logic [95:0] sprite_colors;
  logic [23:0] bg_color, pix_color;
  logic        pix_hit, frame_tick;
  logic [1:0]  pix_id, state;

  int checks = 0;
  int failures = 0;
  int ft_count = 0;
  int id3_hits = 0;
  bit count_id3 = 0;
  int vi0 = -1;
  int vi1 = -1;

  typedef struct {
    int         fr;
    int         x;
    int         y;
    logic [3:0] en;
    logic       hit;
    logic [1:0] id;
    logic [23:0] col;
  } vec_t;
  vec_t vecs[$];

  sprite_frame_scheduler dut (
    .iVGA_CLK      (iVGA_CLK),
    .reset         (reset),
    .blank_n       (blank_n),
    .vs            (vs),
    .pos_wr_valid  (pos_wr_valid),
    .pos_wr_ready  (pos_wr_ready),
    .pos_wr_id     (pos_wr_id),
    .pos_wr_x      (pos_wr_x),
    .pos_wr_y      (pos_wr_y),
    .sprite_en     (sprite_en),
    .sprite_colors (sprite_colors),
    .bg_color      (bg_color),
    .pix_color     (pix_color),
    .pix_hit       (pix_hit),
    .pix_id        (pix_id),
    .frame_tick    (frame_tick),
    .state         (state)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // One clock: sample outputs 1ns after the edge, score the pixel
  // presented two cycles earlier, then advance the expectation pipe.
  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
    if (frame_tick) ft_count++;
    if (count_id3 && pix_hit && pix_id == 2'd3) id3_hits++;
    if (vi1 >= 0) begin
      vec_t v;
      v = vecs[vi1];
      $display("pixel f%0d (%0d,%0d) en=%b : hit=%0d id=%0d color=%06h", v.fr, v.x, v.y, v.en, pix_hit, pix_id, pix_color);
      check($sformatf("hit f%0d (%0d,%0d)", v.fr, v.x, v.y), pix_hit, v.hit);
      check($sformatf("id f%0d (%0d,%0d)", v.fr, v.x, v.y), pix_id, v.id);
      check($sformatf("color f%0d (%0d,%0d)", v.fr, v.x, v.y), pix_color, v.col);
    end
    vi1 = vi0;
    vi0 = -1;
  endtask

  task automatic present_write(input logic [1:0] id, input logic [9:0] x, input logic [8:0] y);
    pos_wr_valid = 1'b1;
    pos_wr_id    = id;
    pos_wr_x     = x;
    pos_wr_y     = y;
  endtask

  // Drive continuous visible pixels for nlines lines of frame fr.
  task automatic run_visible(input int fr, input int nlines, input logic [3:0] def_en);
    for (int y = 0; y < nlines; y++) begin
      for (int x = 0; x < 640; x++) begin
        tick();
        vs        = 1'b1;
        blank_n   = 1'b1;
        sprite_en = def_en;
        for (int i = 0; i < vecs.size(); i++) begin
          if (vecs[i].fr == fr && vecs[i].x == x && vecs[i].y == y) begin
            sprite_en = vecs[i].en;
            vi0 = i;
          end
        end
      end
    end
    tick();
    blank_n   = 1'b0;
    sprite_en = def_en;
    repeat (3) tick();
  endtask

  initial begin
    // Frame 0: slot0 at (100,50), only slot0 enabled.
    vecs.push_back('{0, 100, 50, 4'b0001, 1'b1, 2'd0, C0});
    vecs.push_back('{0,  99, 50, 4'b0001, 1'b0, 2'd0, BG});
    vecs.push_back('{0, 132, 50, 4'b0001, 1'b0, 2'd0, BG});
    vecs.push_back('{0, 100, 49, 4'b0001, 1'b0, 2'd0, BG});
    vecs.push_back('{0, 131, 81, 4'b0001, 1'b1, 2'd0, C0});
    // Frame 1: slot0 (200,10), slot1 (20,0) after last-wins, slot2 (210,10), slot3 (1000,500).
    vecs.push_back('{1,   0,  0, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1,   7,  0, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1,  10,  0, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1,  19,  0, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1,  20,  0, 4'b1111, 1'b1, 2'd1, C1});
    vecs.push_back('{1,  51,  0, 4'b1111, 1'b1, 2'd1, C1});
    vecs.push_back('{1,  52,  0, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1, 199, 10, 4'b1111, 1'b0, 2'd0, BG});
    vecs.push_back('{1, 200, 10, 4'b1111, 1'b1, 2'd0, C0});
    vecs.push_back('{1, 215, 20, 4'b1111, 1'b1, 2'd0, C0});
    vecs.push_back('{1, 215, 21, 4'b1110, 1'b1, 2'd2, C2});
    vecs.push_back('{1, 209, 21, 4'b1110, 1'b0, 2'd0, BG});
    vecs.push_back('{1, 241, 21, 4'b1111, 1'b1, 2'd2, C2});
    vecs.push_back('{1, 242, 21, 4'b1111, 1'b0, 2'd0, BG});
    // Frame 2: after reset, slot2 back at (0,0); slot0 written to (300,0).
    vecs.push_back('{2,   0,  0, 4'b0100, 1'b1, 2'd2, C2});
    vecs.push_back('{2,  31,  0, 4'b0100, 1'b1, 2'd2, C2});
    vecs.push_back('{2,  32,  0, 4'b0100, 1'b0, 2'd0, BG});
    vecs.push_back('{2, 299,  0, 4'b0101, 1'b0, 2'd0, BG});
    vecs.push_back('{2, 300,  0, 4'b0101, 1'b1, 2'd0, C0});

    sprite_colors = {C3, C2, C1, C0};
    bg_color      = BG;
    reset         = 1'b1;
    blank_n       = 1'b0;
    vs            = 1'b1;
    sprite_en     = 4'b0000;
    present_write(2'd1, 10'd300, 9'd0);

    // Reset held three cycles with a write pending.
    repeat (3) begin
      tick();
      check("reset ready", pos_wr_ready, 1'b0);
      check("reset state", state, 2'd0);
      check("reset pix_hit", pix_hit, 1'b0);
    end
    check("reset pix_id", pix_id, 2'd0);
    check("reset pix_color", pix_color, 24'd0);
    check("reset frame_tick", frame_tick, 1'b0);
    reset = 1'b0;
    pos_wr_valid = 1'b0;
    repeat (3) tick();

    // Frame 0 protocol.
    ft_count = 0;
    vs = 1'b0;
    tick();
    check("f0 load state", state, 2'd1);
    check("f0 frame_tick", frame_tick, 1'b1);
    check("f0 load ready", pos_wr_ready, 1'b1);
    present_write(2'd0, 10'd100, 9'd50);
    tick();
    pos_wr_valid = 1'b0;
    check("f0 tick one cycle", frame_tick, 1'b0);
    check("f0 ready held", pos_wr_ready, 1'b1);
    repeat (3) tick();
    check("f0 still load", state, 2'd1);
    vs = 1'b1;
    tick();
    check("f0 commit state", state, 2'd2);
    check("f0 commit ready", pos_wr_ready, 1'b0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check($sformatf("f0 commit cycle %0d", k), state, 2'd2);
    end
    tick();
    check("f0 commit done", state, 2'd0);
    check("f0 frame_tick count", ft_count, 1);
    repeat (4) tick();
    run_visible(0, 82, 4'b0001);

    // Write presented in SCAN must be refused.
    present_write(2'd1, 10'd300, 9'd0);
    tick();
    check("scan write ready", pos_wr_ready, 1'b0);
    check("scan state", state, 2'd0);
    pos_wr_valid = 1'b0;

    // Frame 1 protocol; last write lands in the vs rising-edge cycle.
    vs = 1'b0;
    tick();
    check("f1 load state", state, 2'd1);
    present_write(2'd1, 10'd10,   9'd0);   tick();
    present_write(2'd0, 10'd200,  9'd10);  tick();
    present_write(2'd2, 10'd210,  9'd10);  tick();
    present_write(2'd3, 10'd1000, 9'd500); tick();
    pos_wr_valid = 1'b0;
    tick();
    present_write(2'd1, 10'd20, 9'd0);
    vs = 1'b1;
    tick();
    pos_wr_valid = 1'b0;
    check("f1 commit state", state, 2'd2);
    repeat (4) tick();
    check("f1 commit done", state, 2'd0);
    repeat (4) tick();
    id3_hits  = 0;
    count_id3 = 1'b1;
    run_visible(1, 22, 4'b1111);
    count_id3 = 1'b0;
    check("f1 slot3 clipped hits", id3_hits, 0);

    // Reset in the middle of LOAD discards the pending write.
    vs = 1'b0;
    tick();
    check("f2 load state", state, 2'd1);
    present_write(2'd2, 10'd50, 9'd5);
    tick();
    pos_wr_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("midload reset state", state, 2'd0);
    check("midload reset ready", pos_wr_ready, 1'b0);
    reset = 1'b0;
    tick();
    check("after reset stays scan", state, 2'd0);
    vs = 1'b1;
    repeat (3) tick();
    ft_count = 0;
    vs = 1'b0;
    tick();
    check("f2 reload state", state, 2'd1);
    check("f2 frame_tick", frame_tick, 1'b1);
    present_write(2'd0, 10'd300, 9'd0);
    tick();
    pos_wr_valid = 1'b0;
    vs = 1'b1;
    tick();
    check("f2 commit state", state, 2'd2);
    repeat (4) tick();
    check("f2 commit done", state, 2'd0);
    check("f2 frame_tick count", ft_count, 1);
    repeat (4) tick();
    run_visible(2, 1, 4'b0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
